// File: rtl/fft_bitrev_buffer.sv
// Bit-reversal reorder buffer that sits in front of the radix-2 DIT butterflies.
// It collects one natural-order frame and stores each sample at its bit-reversed
// address. It then replays the frame in address order, so position j carries x[bitrev(j)].
module fft_bitrev_buffer #(
    parameter int N      = 8,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_re,
    input  logic [DATA_W-1:0]    in_im,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_re,
    output logic [DATA_W-1:0]    out_im,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 err_frame
);
    localparam int unsigned LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [LOG2N-1:0]    wr_cnt;
    logic [LOG2N-1:0]    rd_cnt;
    logic [2*DATA_W-1:0] mem [N];

    logic in_xfer, out_xfer, wr_at_end, rd_at_end;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = k[LOG2N-1-i];
        end
        return r;
    endfunction

    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign wr_at_end = (wr_cnt == LAST_IDX);
    assign rd_at_end = (rd_cnt == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a full frame moves to DRAIN, and the last accepted output returns to FILL
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:  if (in_xfer && wr_at_end)   state_nxt = DRAIN;
            DRAIN: if (out_xfer && rd_at_end)  state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Outputs: the read side is a direct view of mem[rd_cnt] while draining, so it holds while stalled
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_re    = '0;
        out_im    = '0;
        out_last  = 1'b0;
        out_idx   = rd_cnt;
        case (state)
            FILL:  in_ready = 1'b1;
            DRAIN: begin
                out_valid        = 1'b1;
                {out_re, out_im} = mem[rd_cnt];
                out_last         = rd_at_end;
            end
            default: ;
        endcase
    end

    // Pointers and framing-error pulse; a short frame rewinds the write pointer and drops its data
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            if (in_xfer) begin
                if (wr_at_end) begin
                    wr_cnt    <= '0;
                    err_frame <= !in_last;
                end else if (in_last) begin
                    wr_cnt    <= '0;
                    err_frame <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + LOG2N'(1);
                end
            end
            if (out_xfer) begin
                rd_cnt <= rd_cnt + LOG2N'(1);
            end
        end
    end

    // Sample storage at the bit-reversed address (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (in_xfer && !rst) begin
            mem[bitrev(wr_cnt)] <= {in_re, in_im};
        end
    end

endmodule

// File: tb/tb_fft_bitrev_buffer.sv
// Self-checking bench for fft_bitrev_buffer: an N=8 instance for directed cases
// and an N=16 instance for randomized back-to-back frames, both against a frame-level model.
module tb_fft_bitrev_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid [2];
    logic        in_last  [2];
    logic        out_ready[2];
    logic [15:0] in_re    [2];
    logic [15:0] in_im    [2];
    logic        in_ready [2];
    logic        out_valid[2];
    logic        out_last [2];
    logic        err      [2];
    logic [15:0] out_re   [2];
    logic [15:0] out_im   [2];
    logic [2:0]  idx8;
    logic [3:0]  idx16;

    always #5 clk = ~clk;

    fft_bitrev_buffer #(.N(8), .DATA_W(16)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_re(in_re[0]), .in_im(in_im[0]), .in_last(in_last[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_re(out_re[0]), .out_im(out_im[0]), .out_idx(idx8),
        .out_last(out_last[0]), .err_frame(err[0])
    );

    fft_bitrev_buffer #(.N(16), .DATA_W(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_re(in_re[1]), .in_im(in_im[1]), .in_last(in_last[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_re(out_re[1]), .out_im(out_im[1]), .out_idx(idx16),
        .out_last(out_last[1]), .err_frame(err[1])
    );

    int checks = 0;
    int errors = 0;

    // Reference model: collected frame, expected replay list, expected error pulse
    int          np[2] = '{8, 16};
    logic [15:0] fill_re[2][16];
    logic [15:0] fill_im[2][16];
    int          fill_n[2];
    logic [15:0] exp_re[2][16];
    logic [15:0] exp_im[2][16];
    int          exp_n[2];
    int          exp_pos[2];
    logic        err_exp[2];
    logic        last_acc[2];
    int          errcnt[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int bitrev_ref(input int j, input int n);
        int r, x;
        r = 0;
        x = j;
        for (int m = n; m > 1; m = m / 2) begin
            r = r * 2 + x % 2;
            x = x / 2;
        end
        return r;
    endfunction

    function automatic logic [31:0] obs_idx(input int d);
        return (d == 0) ? 32'(idx8) : 32'(idx16);
    endfunction

    // One clock: check outputs before the edge, then advance the model by what transferred
    task automatic tick();
        logic oacc[2];
        logic r;
        int   p;
        r = rst;
        for (int d = 0; d < 2; d++) begin
            last_acc[d] = 1'b0;
            oacc[d]     = 1'b0;
            if (!r) begin
                p = exp_n[d] - exp_pos[d];
                check($sformatf("d%0d_in_ready", d), 32'(in_ready[d]), 32'(p == 0));
                check($sformatf("d%0d_out_valid", d), 32'(out_valid[d]), 32'(p != 0));
                check($sformatf("d%0d_exclusive", d), 32'(in_ready[d] & out_valid[d]), 32'd0);
                check($sformatf("d%0d_err_frame", d), 32'(err[d]), 32'(err_exp[d]));
                if (p != 0) begin
                    check($sformatf("d%0d_out_re", d), 32'(out_re[d]), 32'(exp_re[d][exp_pos[d]]));
                    check($sformatf("d%0d_out_im", d), 32'(out_im[d]), 32'(exp_im[d][exp_pos[d]]));
                    check($sformatf("d%0d_out_idx", d), obs_idx(d), 32'(exp_pos[d]));
                    check($sformatf("d%0d_out_last", d), 32'(out_last[d]), 32'(exp_pos[d] == np[d] - 1));
                end
                if (err[d] === 1'b1) errcnt[d]++;
                last_acc[d] = in_valid[d] && (p == 0);
                oacc[d]     = out_ready[d] && (p != 0);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (r) begin
                fill_n[d]  = 0;
                exp_n[d]   = 0;
                exp_pos[d] = 0;
                err_exp[d] = 1'b0;
            end else begin
                err_exp[d] = 1'b0;
                if (oacc[d]) begin
                    exp_pos[d]++;
                    if (exp_pos[d] == exp_n[d]) begin
                        exp_pos[d] = 0;
                        exp_n[d]   = 0;
                    end
                end
                if (last_acc[d]) begin
                    fill_re[d][fill_n[d]] = in_re[d];
                    fill_im[d][fill_n[d]] = in_im[d];
                    fill_n[d]++;
                    if (fill_n[d] == np[d]) begin
                        err_exp[d] = !in_last[d];
                        for (int j = 0; j < np[d]; j++) begin
                            exp_re[d][j] = fill_re[d][bitrev_ref(j, np[d])];
                            exp_im[d][j] = fill_im[d][bitrev_ref(j, np[d])];
                        end
                        exp_n[d]   = np[d];
                        exp_pos[d] = 0;
                        fill_n[d]  = 0;
                    end else if (in_last[d]) begin
                        err_exp[d] = 1'b1;
                        fill_n[d]  = 0;
                    end
                end
            end
        end
    endtask

    task automatic send(input int d, input logic [15:0] re, input logic [15:0] im, input logic last);
        int g;
        g = 0;
        in_valid[d] = 1'b1;
        in_re[d]    = re;
        in_im[d]    = im;
        in_last[d]  = last;
        do begin
            tick();
            g++;
        end while (!last_acc[d] && g < 100);
        check("send_accepted", 32'(last_acc[d]), 32'd1);
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic drain(input int d, input int mode);
        int g;
        g = 0;
        while (exp_n[d] != exp_pos[d] && g < 300) begin
            case (mode)
                0:       out_ready[d] = 1'b1;
                1:       out_ready[d] = (g % 3 == 0);
                default: out_ready[d] = 1'($urandom_range(0, 1));
            endcase
            tick();
            g++;
        end
        out_ready[d] = 1'b0;
        check("drain_done", 32'(exp_n[d] - exp_pos[d]), 32'd0);
    endtask

    initial begin
        int base, s;
        int g;
        logic [15:0] src_re[64];
        logic [15:0] src_im[64];

        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 0; in_last[d] = 0; out_ready[d] = 0;
            in_re[d] = '0; in_im[d] = '0;
            fill_n[d] = 0; exp_n[d] = 0; exp_pos[d] = 0;
            err_exp[d] = 0; last_acc[d] = 0; errcnt[d] = 0;
        end

        // Reset values
        rst = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            check("rst_in_ready", 32'(in_ready[d]), 32'd1);
            check("rst_out_valid", 32'(out_valid[d]), 32'd0);
            check("rst_out_last", 32'(out_last[d]), 32'd0);
            check("rst_out_idx", obs_idx(d), 32'd0);
            check("rst_out_re", 32'(out_re[d]), 32'd0);
            check("rst_out_im", 32'(out_im[d]), 32'd0);
            check("rst_err", 32'(err[d]), 32'd0);
        end
        rst = 1'b0;
        tick();

        // T1: ramp with negated imaginary part, free-flowing output
        base = errcnt[0];
        for (int k = 0; k < 8; k++) send(0, 16'(k), 16'(-k), k == 7);
        drain(0, 0);
        tick();
        check("t1_err_count", 32'(errcnt[0] - base), 32'd0);

        // T2: same frame with output stalls 1,0,0 repeating
        for (int k = 0; k < 8; k++) send(0, 16'(k), 16'(-k), k == 7);
        drain(0, 1);
        tick();

        // T3: short frame (in_last on 5th sample) followed by a good frame
        base = errcnt[0];
        for (int k = 0; k < 5; k++) send(0, 16'(k), 16'(k + 100), k == 4);
        for (int k = 10; k < 18; k++) send(0, 16'(k), 16'(k + 100), k == 17);
        drain(0, 0);
        tick();
        check("t3_err_count", 32'(errcnt[0] - base), 32'd1);

        // T4: full frame with in_last never asserted
        base = errcnt[0];
        for (int k = 0; k < 8; k++) send(0, 16'(k + 40), 16'(k * 3), 1'b0);
        drain(0, 2);
        tick();
        check("t4_err_count", 32'(errcnt[0] - base), 32'd1);

        // T5: reset after three outputs of a drain
        for (int k = 20; k < 28; k++) send(0, 16'(k), 16'(~k), k == 27);
        out_ready[0] = 1'b1;
        repeat (3) tick();
        out_ready[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_in_ready", 32'(in_ready[0]), 32'd1);
        check("t5_out_valid", 32'(out_valid[0]), 32'd0);
        check("t5_out_idx", obs_idx(0), 32'd0);
        for (int k = 30; k < 38; k++) send(0, 16'(k), 16'(k ^ 5), k == 37);
        drain(0, 0);
        tick();

        // T6: N=16, four back-to-back random frames with random valid/ready gaps
        for (int i = 0; i < 64; i++) begin
            src_re[i] = 16'($urandom);
            src_im[i] = 16'($urandom);
        end
        base = errcnt[1];
        s = 0;
        g = 0;
        while (!(s == 64 && exp_n[1] == exp_pos[1] && !in_valid[1]) && g < 3000) begin
            out_ready[1] = ($urandom_range(0, 3) != 0);
            if (!in_valid[1] && s < 64 && $urandom_range(0, 3) != 0) begin
                in_valid[1] = 1'b1;
                in_re[1]    = src_re[s];
                in_im[1]    = src_im[s];
                in_last[1]  = (s % 16 == 15);
            end
            tick();
            if (last_acc[1]) begin
                s++;
                in_valid[1] = 1'b0;
                in_last[1]  = 1'b0;
            end
            g++;
        end
        out_ready[1] = 1'b0;
        check("t6_all_sent", 32'(s), 32'd64);
        check("t6_all_drained", 32'(exp_n[1] - exp_pos[1]), 32'd0);
        tick();
        check("t6_err_count", 32'(errcnt[1] - base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
